f_pc_npc: RTL and testbench

- Fetch-side consumer of the D-stage branch decision: PC register, next-PC selection, F/D pipeline register.
- Takes the `flag` from the D-stage comparator, plus D-stage control (NPCOp, immediates, forwarded rs) and the instruction read from IM.
- Drives the fetch address and latches the F->D instruction/PC pair.
- Delayed-branch MIPS: the instruction after a branch/jump (delay slot) is always fetched and executed; no flush path.

---
 rtl/f_pc_npc_pkg.sv | 12 +
 rtl/f_pc_npc_npc.sv | 26 ++
 rtl/f_pc_npc.sv | 52 +++++
 tb/tb_f_pc_npc.sv | 75 +++++++
 4 files changed

// File: rtl/f_pc_npc_pkg.sv
// f_pc_npc_pkg: next-PC select codes, reset constants and branch-offset helper.
package f_pc_npc_pkg;
  localparam logic [1:0] NPC_PC4 = 2'd0;
  localparam logic [1:0] NPC_B = 2'd1;
  localparam logic [1:0] NPC_J = 2'd2;
  localparam logic [1:0] NPC_JR = 2'd3;
  localparam logic [31:0] PC_INIT = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  function automatic logic [31:0] br_off(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction
endpackage

// File: rtl/f_pc_npc_npc.sv
// f_pc_npc_npc: combinational next-PC mux for a delayed-branch fetch stage.
module f_pc_npc_npc
  import f_pc_npc_pkg::*;
(
  input  logic [31:0] F_pc,
  input  logic [31:0] D_pc,
  input  logic [1:0]  NPCOp,
  input  logic        cmp_flag,
  input  logic [15:0] D_imm16,
  input  logic [25:0] D_imm26,
  input  logic [31:0] D_rs_fwd,
  output logic [31:0] npc
);
  logic [31:0] w_pc4;
  logic [31:0] w_br;
  logic [31:0] w_j;
  assign w_pc4 = F_pc + 32'd4;
  assign w_br = D_pc + 32'd4 + br_off(D_imm16);
  // jump segment comes from the branch's own PC, not the delay-slot PC
  assign w_j = {D_pc[31:28], D_imm26, 2'b00};
  always_comb begin
    npc = (NPCOp == NPC_B && cmp_flag) ? w_br :
          (NPCOp == NPC_J)             ? w_j  :
          (NPCOp == NPC_JR)            ? D_rs_fwd : w_pc4;
  end
endmodule

// File: rtl/f_pc_npc.sv
// f_pc_npc: PC register, next-PC selection and F/D pipeline register.
module f_pc_npc
  import f_pc_npc_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_INIT,
  parameter logic [31:0] INSTR_NOP = NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] im_instr,
  input  logic [1:0]  NPCOp,
  input  logic        cmp_flag,
  input  logic [15:0] D_imm16,
  input  logic [25:0] D_imm26,
  input  logic [31:0] D_rs_fwd,
  output logic [31:0] F_pc,
  output logic [31:0] D_instr,
  output logic [31:0] D_pc,
  output logic [31:0] D_pc8
);
  logic [31:0] r_f_pc;
  logic [31:0] r_d_pc;
  logic [31:0] r_d_instr;
  logic [31:0] w_npc;
  f_pc_npc_npc u_npc (
    .F_pc(r_f_pc),
    .D_pc(r_d_pc),
    .NPCOp(NPCOp),
    .cmp_flag(cmp_flag),
    .D_imm16(D_imm16),
    .D_imm26(D_imm26),
    .D_rs_fwd(D_rs_fwd),
    .npc(w_npc)
  );
  // a stalled redirect is simply dropped; D re-evaluates it next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_f_pc <= PC_RESET;
      r_d_pc <= PC_RESET;
      r_d_instr <= INSTR_NOP;
    end else if (!stall) begin
      r_f_pc <= w_npc;
      r_d_pc <= r_f_pc;
      r_d_instr <= im_instr;
    end
  end
  assign F_pc = r_f_pc;
  assign D_pc = r_d_pc;
  assign D_instr = r_d_instr;
  assign D_pc8 = r_d_pc + 32'd8;
endmodule

// File: tb/tb_f_pc_npc.sv
// tb_f_pc_npc: directed checks of reset, branch/jump redirect, stall and wrap.
module tb_f_pc_npc;
  logic clk = 0;
  logic reset, stall, cmp_flag;
  logic [31:0] im_instr, D_rs_fwd, F_pc, D_instr, D_pc, D_pc8;
  logic [1:0] NPCOp;
  logic [15:0] D_imm16;
  logic [25:0] D_imm26;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  // instruction memory: word tagged with its own address
  assign im_instr = {16'hC0DE, F_pc[15:0]};
  f_pc_npc dut (
    .clk(clk), .reset(reset), .stall(stall), .im_instr(im_instr),
    .NPCOp(NPCOp), .cmp_flag(cmp_flag), .D_imm16(D_imm16), .D_imm26(D_imm26),
    .D_rs_fwd(D_rs_fwd), .F_pc(F_pc), .D_instr(D_instr), .D_pc(D_pc), .D_pc8(D_pc8)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk3(input string tag, input logic [31:0] f, input logic [31:0] d, input logic [31:0] di);
    chk({tag, ".F_pc"}, F_pc, f);
    chk({tag, ".D_pc"}, D_pc, d);
    chk({tag, ".D_instr"}, D_instr, di);
  endtask
  initial begin
    reset = 1; stall = 0; NPCOp = 2'd0; cmp_flag = 0;
    D_imm16 = 0; D_imm26 = 0; D_rs_fwd = 0;
    step; step;
    chk3("rst", 32'h3000, 32'h3000, 32'h0);
    chk("rst.D_pc8", D_pc8, 32'h3008);
    reset = 0;
    step; chk3("seq1", 32'h3004, 32'h3000, 32'hC0DE3000);
    step; chk3("seq2", 32'h3008, 32'h3004, 32'hC0DE3004);
    step; chk3("seq3", 32'h300C, 32'h3008, 32'hC0DE3008);
    NPCOp = 2'd1; cmp_flag = 1; D_imm16 = 16'hFFFE;
    step; chk3("beq_t", 32'h3004, 32'h300C, 32'hC0DE300C);
    NPCOp = 2'd0;
    step; step; chk3("pre_nt", 32'h300C, 32'h3008, 32'hC0DE3008);
    NPCOp = 2'd1; cmp_flag = 0;
    step; chk3("beq_nt", 32'h3010, 32'h300C, 32'hC0DE300C);
    NPCOp = 2'd0;
    step; chk3("pre_j", 32'h3014, 32'h3010, 32'hC0DE3010);
    NPCOp = 2'd2; D_imm26 = 26'h0000C10;
    step; chk3("j", 32'h3040, 32'h3014, 32'hC0DE3014);
    chk("j.D_pc8", D_pc8, 32'h301C);
    NPCOp = 2'd3; D_rs_fwd = 32'h3100;
    step; chk3("jr_slot", 32'h3100, 32'h3040, 32'hC0DE3040);
    NPCOp = 2'd1; cmp_flag = 1; D_imm16 = 16'h0004; stall = 1;
    step; chk3("stall1", 32'h3100, 32'h3040, 32'hC0DE3040);
    cmp_flag = 0;
    step; chk3("stall2", 32'h3100, 32'h3040, 32'hC0DE3040);
    cmp_flag = 1; stall = 0;
    step; chk3("unstall_b", 32'h3054, 32'h3100, 32'hC0DE3100);
    NPCOp = 2'd3; D_rs_fwd = 32'hFFFF_FFFE;
    step; chk("jr_nomask", F_pc, 32'hFFFF_FFFE);
    NPCOp = 2'd0;
    step; chk("wrap.F_pc", F_pc, 32'h0000_0002);
    chk("wrap.D_pc8", D_pc8, 32'h0000_0006);
    NPCOp = 2'd2; D_imm26 = 26'h0000001;
    step; chk("j_seg", F_pc, 32'hF000_0004);
    NPCOp = 2'd3; D_rs_fwd = 32'h5000; stall = 1; reset = 1;
    step; chk3("rst_stall", 32'h3000, 32'h3000, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
